// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver and the JK counter blocks.
//   DC_FILL_ZERO / DC_FILL_ONE : how the don't-care cells of the JK excitation table are filled
//   jk_excite(q, t, fill)      : {j, k} that moves one JK flop from q to t
package jk_pkg;

  localparam int unsigned DC_FILL_ZERO = 0;
  localparam int unsigned DC_FILL_ONE  = 1;

  // Fill 0 turns every X into 0 (minimal toggling). Fill 1 turns every X into 1,
  // giving the J = q | t, K = ~(q & t) form.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input int unsigned fill);
    logic j;
    logic k;
    if (fill == DC_FILL_ONE) begin
      j = q | t;
      k = ~(q & t);
    end else begin
      j = ~q & t;
      k = q & ~t;
    end
    return {j, k};
  endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Target stream and JK bank connection for jk_excite_driver.
//   tgt_valid_i / tgt_ready_o / tgt_data_i : target word handshake into the driver
//   j_o / k_o / jk_valid_o                 : registered excitation towards the JK bank
//   q_fb_i                                 : bank Q feedback
// slave is the driver side, master is the producer/bank side.
interface jk_excite_driver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             tgt_valid_i;
  logic             tgt_ready_o;
  logic [WIDTH-1:0] tgt_data_i;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;
  logic             jk_valid_o;
  logic [WIDTH-1:0] q_fb_i;

  modport slave (
    input  tgt_valid_i, tgt_data_i, q_fb_i,
    output tgt_ready_o, j_o, k_o, jk_valid_o
  );

  modport master (
    output tgt_valid_i, tgt_data_i, q_fb_i,
    input  tgt_ready_o, j_o, k_o, jk_valid_o
  );
endinterface

// File: rtl/jk_sync_fifo.sv
// Small synchronous FIFO holding target words.
//   clk, rst   : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i (caller guarantees not full)
//   pop_i      : drop the head entry (caller guarantees not empty)
//   rdata_o    : head entry, taken straight from the register array
//   full_o, empty_o, level_o : occupancy status
module jk_sync_fifo #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW-1:0] PtrOne   = 1;
  localparam logic [AW:0]   CntOne   = 1;
  localparam logic [AW:0]   CntFull  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a bank of WIDTH external JK flops through a stream of target words and checks the
// bank's Q feedback two cycles after each issue.
//   clk, rst      : clock, synchronous active-low reset (shared with the bank)
//   bus (slave)   : target handshake in, J/K excitation out, Q feedback in
//   clr_err_i     : clear the sticky error
//   err_o         : sticky mismatch flag
//   err_mask_o    : differing bits at the first mismatch since the last clear
//   level_o       : target FIFO occupancy
//   issued_o      : number of targets issued, wraps
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter  int unsigned WIDTH   = 4,
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned DC_FILL = 0,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  jk_excite_driver_if.slave   bus,
  input  logic                clr_err_i,
  output logic                err_o,
  output logic [WIDTH-1:0]    err_mask_o,
  output logic [LW-1:0]       level_o,
  output logic [CNT_W-1:0]    issued_o
);

  localparam logic [CNT_W-1:0] IssOne = 1;

  logic             push, pop, full, empty;
  logic [WIDTH-1:0] head;

  // Ready is held low while reset is asserted, independent of the FIFO state.
  assign bus.tgt_ready_o = rst & ~full;
  assign push            = bus.tgt_valid_i & bus.tgt_ready_o;
  assign pop             = ~empty;

  jk_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.tgt_data_i),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  logic [WIDTH-1:0] j_q, k_q, shadow_q, exp_q, chk_exp_q, mask_q;
  logic             vld_q, chk_v_q, err_q;
  logic [CNT_W-1:0] issued_q;

  logic [WIDTH-1:0] exc_j, exc_k, mismatch, mask_d;
  logic             err_d;

  always_comb begin
    exc_j = '0;
    exc_k = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      {exc_j[i], exc_k[i]} = jk_excite(shadow_q[i], head[i], DC_FILL);
    end
  end

  // A new mismatch takes priority over a clear arriving on the same edge.
  always_comb begin
    err_d    = err_q;
    mask_d   = mask_q;
    mismatch = bus.q_fb_i ^ chk_exp_q;
    if (chk_v_q && (mismatch != '0) && (!err_q || clr_err_i)) begin
      err_d  = 1'b1;
      mask_d = mismatch;
    end else if (clr_err_i) begin
      err_d  = 1'b0;
      mask_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      j_q       <= '0;
      k_q       <= '0;
      vld_q     <= 1'b0;
      shadow_q  <= '0;
      exp_q     <= '0;
      chk_exp_q <= '0;
      chk_v_q   <= 1'b0;
      err_q     <= 1'b0;
      mask_q    <= '0;
      issued_q  <= '0;
    end else begin
      if (pop) begin
        j_q      <= exc_j;
        k_q      <= exc_k;
        vld_q    <= 1'b1;
        shadow_q <= head;
        exp_q    <= head;
        issued_q <= issued_q + IssOne;
      end else begin
        // J=K=0 holds the bank.
        j_q   <= '0;
        k_q   <= '0;
        vld_q <= 1'b0;
      end
      // Extra stage: the bank only reflects an issue one edge after jk_valid_o.
      chk_exp_q <= exp_q;
      chk_v_q   <= vld_q;
      err_q     <= err_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.j_o        = j_q;
  assign bus.k_o        = k_q;
  assign bus.jk_valid_o = vld_q;
  assign err_o          = err_q;
  assign err_mask_o     = mask_q;
  assign issued_o       = issued_q;

endmodule
